icache_miss_ctrl: RTL and testbench

Lookup-and-refill controller for the instruction cache. It accepts fetch lookups, indexes the 2-way tag/valid array, and samples that array's per-way `hit` vector one cycle later. On a miss it selects a victim by per-set LRU, fetches the line from memory word by word, writes the data array, and then commits the tag and valid bit. It sits between the fetch stage and the memory bus, directly driving the tag/valid array's read and write ports.

---
 rtl/icache_miss_ctrl_if.sv | 48 ++++
 rtl/icache_miss_ctrl.sv | 128 ++++++++++++
 tb/tb_icache_miss_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_miss_ctrl_if.sv
// Bundle of fetch, tag/valid array, memory and data-array signals around the
// icache miss controller. The controller uses the slave side; its environment uses master.
interface icache_miss_ctrl_if #(
    parameter int tag_width    = 25,
    parameter int index_width  = 4,
    parameter int offset_width = 3,
    parameter int way          = 2
);
    logic                                      req_valid;
    logic [tag_width-1:0]                      req_tag;
    logic [index_width-1:0]                    req_index;
    logic                                      req_ready;

    logic [index_width-1:0]                    TagV_addr_read;
    logic [tag_width-1:0]                      TagV_din_compare;
    logic [way-1:0]                            hit;
    logic [way-1:0]                            TagV_we;
    logic [index_width-1:0]                    TagV_addr_write;
    logic [tag_width-1:0]                      TagV_din_write;

    logic                                      resp_hit;
    logic                                      resp_way;
    logic                                      refill_done;

    logic                                      mem_rd_req;
    logic [tag_width+index_width+offset_width-1:0] mem_rd_addr;
    logic                                      mem_rd_ready;
    logic                                      mem_rvalid;
    logic [31:0]                               mem_rdata;

    logic [way-1:0]                            data_we;
    logic [index_width+offset_width-3:0]       data_waddr;
    logic [31:0]                               data_wdata;

    modport slave (
        input  req_valid, req_tag, req_index, hit, mem_rd_ready, mem_rvalid, mem_rdata,
        output req_ready, TagV_addr_read, TagV_din_compare, TagV_we, TagV_addr_write,
               TagV_din_write, resp_hit, resp_way, refill_done, mem_rd_req, mem_rd_addr,
               data_we, data_waddr, data_wdata
    );

    modport master (
        output req_valid, req_tag, req_index, hit, mem_rd_ready, mem_rvalid, mem_rdata,
        input  req_ready, TagV_addr_read, TagV_din_compare, TagV_we, TagV_addr_write,
               TagV_din_write, resp_hit, resp_way, refill_done, mem_rd_req, mem_rd_addr,
               data_we, data_waddr, data_wdata
    );
endinterface

// File: rtl/icache_miss_ctrl.sv
// 2-way icache lookup/refill controller: tag lookup, per-set LRU victim choice,
// word-by-word line refill into the data array, then tag/valid commit.
module icache_miss_ctrl #(
    parameter int tag_width    = 25,
    parameter int index_width  = 4,
    parameter int offset_width = 3,
    parameter int way          = 2
) (
    input logic               clk,
    input logic               rstn,
    icache_miss_ctrl_if.slave bus
);
    localparam int BW   = offset_width - 2;
    localparam int W    = 1 << BW;
    localparam int SETS = 1 << index_width;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, COMMIT} state_e;

    state_e                 state_q, state_d;
    logic [tag_width-1:0]   tag_q, tag_d;
    logic [index_width-1:0] idx_q, idx_d;
    logic                   victim_q, victim_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [SETS-1:0]        lru_q, lru_d;

    logic [way-1:0] hit_w;
    logic           any_hit;
    logic           hit_way;
    logic           last_beat;

    assign hit_w     = bus.hit;
    assign any_hit   = |hit_w;
    assign hit_way   = ~hit_w[0];
    assign last_beat = (beat_q == BW'(W - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            victim_q <= 1'b0;
            beat_q   <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            victim_q <= victim_d;
            beat_q   <= beat_d;
            lru_q    <= lru_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        victim_d = victim_q;
        beat_d   = beat_q;
        lru_d    = lru_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                tag_d   = bus.req_tag;
                idx_d   = bus.req_index;
                state_d = LOOKUP;
            end
            LOOKUP: if (any_hit) begin
                lru_d[idx_q] = ~hit_way;
                state_d      = IDLE;
            end else begin
                victim_d = lru_q[idx_q];
                state_d  = MISS;
            end
            MISS: if (bus.mem_rd_ready) begin
                beat_d  = '0;
                state_d = REFILL;
            end
            REFILL: if (bus.mem_rvalid) begin
                beat_d = beat_q + 1'b1;
                if (last_beat) state_d = COMMIT;
            end
            COMMIT: begin
                lru_d[idx_q] = ~victim_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the registered state; the hit response and the data-array
    // write track their inputs (hit, mem_rvalid) in the same cycle so the
    // lookup answers in LOOKUP and each beat is written as it arrives.
    always_comb begin
        bus.req_ready        = (state_q == IDLE);
        bus.TagV_addr_read   = idx_q;
        bus.TagV_din_compare = tag_q;
        bus.TagV_we          = '0;
        bus.TagV_addr_write  = idx_q;
        bus.TagV_din_write   = tag_q;
        bus.resp_hit         = 1'b0;
        bus.resp_way         = 1'b0;
        bus.refill_done      = 1'b0;
        bus.mem_rd_req       = 1'b0;
        bus.mem_rd_addr      = {tag_q, idx_q, {offset_width{1'b0}}};
        bus.data_we          = '0;
        bus.data_waddr       = {idx_q, beat_q};
        bus.data_wdata       = rstn ? bus.mem_rdata : 32'h0;
        unique case (state_q)
            IDLE: begin
                // Array read is one cycle, so address it straight from the request.
                bus.TagV_addr_read   = rstn ? bus.req_index : '0;
                bus.TagV_din_compare = rstn ? bus.req_tag : '0;
            end
            LOOKUP: begin
                bus.resp_hit = any_hit;
                bus.resp_way = any_hit & hit_way;
            end
            MISS: bus.mem_rd_req = 1'b1;
            REFILL: bus.data_we[victim_q] = bus.mem_rvalid;
            COMMIT: begin
                bus.TagV_we[victim_q] = 1'b1;
                bus.refill_done       = 1'b1;
                bus.resp_way          = victim_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Bench for icache_miss_ctrl: models the tag/valid array, drives fetch and memory
// traffic, and checks every response against a per-set cache contents model.
module tb_icache_miss_ctrl;
    localparam int TW = 25, IW = 4, OW = 3, NW = 2;
    localparam int W  = 1 << (OW - 2);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    icache_miss_ctrl_if #(.tag_width(TW), .index_width(IW), .offset_width(OW), .way(NW)) bus_if ();

    icache_miss_ctrl #(.tag_width(TW), .index_width(IW), .offset_width(OW), .way(NW)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_if)
    );

    // Tag/valid array environment: registered read, compare on the read data.
    logic [15:0][1:0]          tv_val = '0;
    logic [15:0][1:0][TW-1:0]  tv_tag;
    logic [IW-1:0]             rd_idx_q = '0;
    logic [TW-1:0]             rd_tag_q = '0;
    logic                      force_hit = 1'b0;
    logic [1:0]                arr_hit;

    always @(posedge clk) begin
        rd_idx_q <= bus_if.TagV_addr_read;
        rd_tag_q <= bus_if.TagV_din_compare;
        for (int w = 0; w < 2; w++)
            if (bus_if.TagV_we[w]) begin
                tv_val[bus_if.TagV_addr_write][w] <= 1'b1;
                tv_tag[bus_if.TagV_addr_write][w] <= bus_if.TagV_din_write;
            end
    end
    always_comb
        for (int w = 0; w < 2; w++)
            arr_hit[w] = tv_val[rd_idx_q][w] && (tv_tag[rd_idx_q][w] == rd_tag_q);
    assign bus_if.hit = force_hit ? 2'b11 : arr_hit;

    // Reference model: what the cache should contain, and which way each set evicts next.
    logic [TW-1:0] rt [16][2];
    bit            rv [16][2];
    bit            rl [16];

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string ph);
        chk({ph, "_req_ready"},   64'(bus_if.req_ready), 64'd1);
        chk({ph, "_mem_rd_req"},  64'(bus_if.mem_rd_req), 64'd0);
        chk({ph, "_tagv_we"},     64'(bus_if.TagV_we), 64'd0);
        chk({ph, "_data_we"},     64'(bus_if.data_we), 64'd0);
        chk({ph, "_resp_hit"},    64'(bus_if.resp_hit), 64'd0);
        chk({ph, "_refill_done"}, 64'(bus_if.refill_done), 64'd0);
    endtask

    task automatic chk_reset_outs(input string ph);
        chk_quiet(ph);
        chk({ph, "_resp_way"},   64'(bus_if.resp_way), 64'd0);
        chk({ph, "_rd_addr"},    64'(bus_if.mem_rd_addr), 64'd0);
        chk({ph, "_tv_raddr"},   64'(bus_if.TagV_addr_read), 64'd0);
        chk({ph, "_tv_cmp"},     64'(bus_if.TagV_din_compare), 64'd0);
        chk({ph, "_tv_waddr"},   64'(bus_if.TagV_addr_write), 64'd0);
        chk({ph, "_tv_wdin"},    64'(bus_if.TagV_din_write), 64'd0);
        chk({ph, "_data_waddr"}, 64'(bus_if.data_waddr), 64'd0);
        chk({ph, "_data_wdata"}, 64'(bus_if.data_wdata), 64'd0);
    endtask

    // One fetch transaction. wt: cycles mem_rd_ready is held low; gaps: bit b
    // inserts an idle cycle before beat b; f11 forces both hit bits; abort pulls
    // reset right after beat 0 is written.
    task automatic do_req(input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                          input int wt, input int gaps, input bit f11, input bit abort);
        bit   e_hit;
        bit   e_way;
        bit   vic;
        logic [63:0] e_addr;
        logic [31:0] wd;
        int   k;
        k = 0;
        while (!bus_if.req_ready && k < 50) begin
            tick();
            k++;
        end
        chk("idle_ready", 64'(bus_if.req_ready), 64'd1);

        e_hit = 1'b0;
        e_way = 1'b0;
        for (int w = 1; w >= 0; w--)
            if (rv[idx][w] && rt[idx][w] == tag) begin
                e_hit = 1'b1;
                e_way = w[0];
            end
        if (f11) begin
            e_hit = 1'b1;
            e_way = 1'b0;
        end

        bus_if.req_valid = 1'b1;
        bus_if.req_tag   = tag;
        bus_if.req_index = idx;
        force_hit        = f11;
        #1;
        chk("idle_tv_raddr", 64'(bus_if.TagV_addr_read), 64'(idx));
        chk("idle_tv_cmp",   64'(bus_if.TagV_din_compare), 64'(tag));
        tick();
        bus_if.req_valid = 1'b0;
        bus_if.req_tag   = TW'($urandom);
        bus_if.req_index = IW'($urandom);
        #1;
        chk("lk_resp_hit",  64'(bus_if.resp_hit), 64'(e_hit));
        chk("lk_ready",     64'(bus_if.req_ready), 64'd0);
        chk("lk_mem_req",   64'(bus_if.mem_rd_req), 64'd0);
        chk("lk_tv_raddr",  64'(bus_if.TagV_addr_read), 64'(idx));
        if (e_hit) begin
            chk("lk_resp_way", 64'(bus_if.resp_way), 64'(e_way));
            rl[idx] = ~e_way;
            tick();
            force_hit = 1'b0;
            #1;
            chk_quiet("hit_after");
            return;
        end
        force_hit = 1'b0;
        vic    = rl[idx];
        e_addr = (64'(tag) << (IW + OW)) | (64'(idx) << OW);
        tick();
        for (int i = 0; i < wt; i++) begin
            chk("miss_req_wait",  64'(bus_if.mem_rd_req), 64'd1);
            chk("miss_addr_wait", bus_if.mem_rd_addr, e_addr);
            tick();
        end
        bus_if.mem_rd_ready = 1'b1;
        #1;
        chk("miss_req",  64'(bus_if.mem_rd_req), 64'd1);
        chk("miss_addr", bus_if.mem_rd_addr, e_addr);
        tick();
        bus_if.mem_rd_ready = 1'b0;
        for (int b = 0; b < W; b++) begin
            if (gaps[b]) begin
                bus_if.mem_rvalid = 1'b0;
                #1;
                chk("gap_data_we",  64'(bus_if.data_we), 64'd0);
                chk("gap_mem_req",  64'(bus_if.mem_rd_req), 64'd0);
                tick();
            end
            wd = $urandom;
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = wd;
            #1;
            chk("beat_we",    64'(bus_if.data_we), 64'(1 << vic));
            chk("beat_waddr", 64'(bus_if.data_waddr), 64'(idx * W + b));
            chk("beat_wdata", 64'(bus_if.data_wdata), 64'(wd));
            chk("beat_done",  64'(bus_if.refill_done), 64'd0);
            chk("beat_tv_we", 64'(bus_if.TagV_we), 64'd0);
            tick();
            if (abort) begin
                bus_if.mem_rvalid = 1'b0;
                bus_if.mem_rdata  = 32'hDEAD_BEEF;
                bus_if.req_tag    = TW'($urandom) | 1;
                bus_if.req_index  = IW'($urandom) | 1;
                rstn = 1'b0;
                #1;
                chk_reset_outs("abort");
                for (int s = 0; s < 16; s++) rl[s] = 1'b0;
                tick();
                rstn = 1'b1;
                bus_if.mem_rdata = '0;
                return;
            end
        end
        bus_if.mem_rvalid = 1'b0;
        #1;
        chk("cm_tv_we",    64'(bus_if.TagV_we), 64'(1 << vic));
        chk("cm_tv_waddr", 64'(bus_if.TagV_addr_write), 64'(idx));
        chk("cm_tv_wdin",  64'(bus_if.TagV_din_write), 64'(tag));
        chk("cm_done",     64'(bus_if.refill_done), 64'd1);
        chk("cm_resp_way", 64'(bus_if.resp_way), 64'(vic));
        chk("cm_data_we",  64'(bus_if.data_we), 64'd0);
        rt[idx][vic] = tag;
        rv[idx][vic] = 1'b1;
        rl[idx]      = ~vic;
        tick();
        #1;
        chk_quiet("cm_after");
    endtask

    initial begin
        logic [TW-1:0] pool [6];
        for (int s = 0; s < 16; s++) begin
            rl[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                rv[s][w] = 1'b0;
                rt[s][w] = '0;
            end
        end
        bus_if.req_valid    = 1'b0;
        bus_if.req_tag      = 25'h1ABCDE;
        bus_if.req_index    = 4'hA;
        bus_if.mem_rd_ready = 1'b0;
        bus_if.mem_rvalid   = 1'b0;
        bus_if.mem_rdata    = 32'h1234_5678;
        #2;
        chk_reset_outs("reset");
        @(negedge clk);
        rstn = 1'b1;
        bus_if.mem_rdata = '0;

        do_req(25'h0AB, 4'd3, 0, 0, 1'b0, 1'b0);
        do_req(25'h0AB, 4'd3, 0, 0, 1'b0, 1'b0);
        do_req(25'h0CD, 4'd3, 0, 0, 1'b0, 1'b0);
        do_req(25'h0EF, 4'd3, 0, 0, 1'b0, 1'b0);
        do_req(25'h111, 4'd9, 5, 2, 1'b0, 1'b0);
        do_req(25'h0EF, 4'd3, 0, 0, 1'b0, 1'b0);
        do_req(25'h222, 4'd5, 0, 0, 1'b1, 1'b0);
        do_req(25'h333, 4'd5, 0, 0, 1'b0, 1'b0);
        do_req(25'h1234, 4'd7, 0, 0, 1'b0, 1'b1);
        do_req(25'h1234, 4'd7, 1, 0, 1'b0, 1'b0);
        do_req(25'h1234, 4'd7, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) pool[i] = TW'($urandom);
        for (int t = 0; t < 60; t++)
            do_req(pool[$urandom_range(0, 5)], IW'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0), 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
